// File: rtl/sump_cmd_receiver_pkg.sv
// Shared encodings for the SUMP receive path: UART bit FSM states, command FSM states,
// the long-command flag position and the SUMP short opcodes the decoder acts on.
package sump_cmd_receiver_pkg;

  typedef enum logic [2:0] {
    RX_IDLE  = 3'd0,
    RX_START = 3'd1,
    RX_DATA  = 3'd2,
    RX_STOP  = 3'd3,
    RX_BREAK = 3'd4
  } rx_state_t;

  typedef enum logic {
    CMD_OP   = 1'b0,
    CMD_DATA = 1'b1
  } cmd_state_t;

  localparam int LONG_CMD_BIT = 7;

  localparam logic [7:0] SUMP_RESET = 8'h00;
  localparam logic [7:0] SUMP_RUN   = 8'h01;
  localparam logic [7:0] SUMP_ID    = 8'h02;
  localparam logic [7:0] SUMP_XON   = 8'h11;
  localparam logic [7:0] SUMP_XOFF  = 8'h13;

  function automatic logic is_long_cmd(input logic [7:0] b);
    return b[LONG_CMD_BIT];
  endfunction

endpackage

// File: rtl/sump_cmd_receiver_rx_byte.sv
// 8N1 UART byte receiver (module uart_rx_byte): two-flop synchroniser plus bit FSM.
// Emits one-cycle strobes for a good byte or a bad stop bit.
//
// state    | meaning
// RX_IDLE  | line idle, waiting for falling edge on rxs
// RX_START | counting to mid start bit to reject glitches
// RX_DATA  | sampling 8 data bits mid-bit, LSB first
// RX_STOP  | sampling the stop bit
// RX_BREAK | stop bit was low, waiting for line to return high
module uart_rx_byte
  import sump_cmd_receiver_pkg::*;
#(
  parameter int BITLENGTH = 16
) (
  input  logic       clock,
  input  logic       extReset_n,
  input  logic       rx,
  output logic [7:0] rx_byte,
  output logic       rx_byte_valid,
  output logic       frame_err
);

  localparam logic [15:0] HALF_M1 = 16'(BITLENGTH / 2 - 1);
  localparam logic [15:0] FULL_M1 = 16'(BITLENGTH - 1);

  rx_state_t   state;
  logic        rx_meta;
  logic        rxs;
  logic [15:0] cnt;
  logic [2:0]  idx;
  logic [7:0]  shreg;

  always_ff @(posedge clock or negedge extReset_n) begin
    if (!extReset_n) begin
      rx_meta       <= 1'b1;
      rxs           <= 1'b1;
      state         <= RX_IDLE;
      cnt           <= '0;
      idx           <= '0;
      shreg         <= '0;
      rx_byte       <= '0;
      rx_byte_valid <= 1'b0;
      frame_err     <= 1'b0;
    end else begin
      rx_meta       <= rx;
      rxs           <= rx_meta;
      rx_byte_valid <= 1'b0;
      frame_err     <= 1'b0;
      case (state)
        RX_IDLE: begin
          if (!rxs) begin
            state <= RX_START;
            cnt   <= '0;
          end
        end
        RX_START: begin
          if (cnt == HALF_M1) begin
            cnt   <= '0;
            idx   <= '0;
            state <= rxs ? RX_IDLE : RX_DATA;
          end else begin
            cnt <= cnt + 16'd1;
          end
        end
        RX_DATA: begin
          if (cnt == FULL_M1) begin
            cnt   <= '0;
            shreg <= {rxs, shreg[7:1]};
            idx   <= idx + 3'd1;
            if (idx == 3'd7) state <= RX_STOP;
          end else begin
            cnt <= cnt + 16'd1;
          end
        end
        RX_STOP: begin
          if (cnt == FULL_M1) begin
            cnt <= '0;
            if (rxs) begin
              rx_byte       <= shreg;
              rx_byte_valid <= 1'b1;
              state         <= RX_IDLE;
            end else begin
              frame_err <= 1'b1;
              state     <= RX_BREAK;
            end
          end else begin
            cnt <= cnt + 16'd1;
          end
        end
        RX_BREAK: begin
          if (rxs) state <= RX_IDLE;
        end
        default: state <= RX_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/sump_cmd_receiver.sv
// SUMP command receiver: UART bytes grouped into short (1 byte) or long (opcode + 4 data
// bytes) commands, each presented with a one-cycle execute strobe.
// Optional inter-byte timeout for long commands: define SUMP_RX_TIMEOUT_EN.
//
// state    | meaning
// CMD_OP   | expecting an opcode byte
// CMD_DATA | collecting data bytes of a long command
module sump_cmd_receiver
  import sump_cmd_receiver_pkg::*;
#(
  parameter int FREQ         = 100000000,
  parameter int RATE         = 115200,
  parameter int BITLENGTH    = FREQ / RATE,
  parameter int TIMEOUT_BITS = 1024
) (
  input  logic        clock,
  input  logic        extReset_n,
  input  logic        rx,
  output logic [7:0]  opcode,
  output logic [31:0] opdata,
  output logic        execute,
  output logic [7:0]  rx_byte,
  output logic        rx_byte_valid,
  output logic        frame_err
);

  if (BITLENGTH < 4 || BITLENGTH > 65535) begin : g_bad_bitlength
    $error("sump_cmd_receiver: BITLENGTH out of range 4..65535");
  end
  if (TIMEOUT_BITS < 1 || TIMEOUT_BITS > 65535) begin : g_bad_timeout
    $error("sump_cmd_receiver: TIMEOUT_BITS out of range 1..65535");
  end

  cmd_state_t  cmd_state;
  logic [1:0]  data_idx;
  logic [7:0]  op_hold;
  logic [23:0] data_buf;
  logic        timeout_hit;

  uart_rx_byte #(
    .BITLENGTH(BITLENGTH)
  ) u_rx (
    .clock        (clock),
    .extReset_n   (extReset_n),
    .rx           (rx),
    .rx_byte      (rx_byte),
    .rx_byte_valid(rx_byte_valid),
    .frame_err    (frame_err)
  );

`ifdef SUMP_RX_TIMEOUT_EN
  localparam logic [15:0] TICK_M1 = 16'(BITLENGTH - 1);
  localparam logic [15:0] TO_M1   = 16'(TIMEOUT_BITS - 1);

  logic [15:0] tick_cnt;
  logic [15:0] bit_periods;

  // Idle time is measured only while a long command is partially assembled.
  always_ff @(posedge clock or negedge extReset_n) begin
    if (!extReset_n) begin
      tick_cnt    <= '0;
      bit_periods <= '0;
    end else if (cmd_state != CMD_DATA || rx_byte_valid) begin
      tick_cnt    <= '0;
      bit_periods <= '0;
    end else if (tick_cnt == TICK_M1) begin
      tick_cnt    <= '0;
      bit_periods <= bit_periods + 16'd1;
    end else begin
      tick_cnt <= tick_cnt + 16'd1;
    end
  end

  assign timeout_hit = (cmd_state == CMD_DATA) && !rx_byte_valid &&
                       (tick_cnt == TICK_M1) && (bit_periods == TO_M1);
`else
  assign timeout_hit = 1'b0;
`endif

  always_ff @(posedge clock or negedge extReset_n) begin
    if (!extReset_n) begin
      cmd_state <= CMD_OP;
      data_idx  <= '0;
      op_hold   <= '0;
      data_buf  <= '0;
      opcode    <= '0;
      opdata    <= '0;
      execute   <= 1'b0;
    end else begin
      execute <= 1'b0;
      if (frame_err || timeout_hit) begin
        cmd_state <= CMD_OP;
      end else if (rx_byte_valid) begin
        case (cmd_state)
          CMD_OP: begin
            if (is_long_cmd(rx_byte)) begin
              op_hold   <= rx_byte;
              data_idx  <= '0;
              cmd_state <= CMD_DATA;
            end else begin
              opcode  <= rx_byte;
              opdata  <= '0;
              execute <= 1'b1;
            end
          end
          CMD_DATA: begin
            case (data_idx)
              2'd0: data_buf[7:0]   <= rx_byte;
              2'd1: data_buf[15:8]  <= rx_byte;
              2'd2: data_buf[23:16] <= rx_byte;
              default: begin
                opcode    <= op_hold;
                opdata    <= {rx_byte, data_buf};
                execute   <= 1'b1;
                cmd_state <= CMD_OP;
              end
            endcase
            data_idx <= data_idx + 2'd1;
          end
          default: cmd_state <= CMD_OP;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_sump_cmd_receiver.sv
// Self-checking bench for sump_cmd_receiver: table vectors, corner sequences, random commands.
module tb_sump_cmd_receiver;

  localparam int FREQ    = 16;
  localparam int RATE    = 1;
  localparam int BL      = FREQ / RATE;
  localparam int TO_BITS = 64;

  logic        clock = 1'b0;
  logic        extReset_n;
  logic        rx;
  logic [7:0]  opcode;
  logic [31:0] opdata;
  logic        execute;
  logic [7:0]  rx_byte;
  logic        rx_byte_valid;
  logic        frame_err;

  always #5 clock = ~clock;

  sump_cmd_receiver #(
    .FREQ(FREQ), .RATE(RATE), .TIMEOUT_BITS(TO_BITS)
  ) dut (
    .clock(clock), .extReset_n(extReset_n), .rx(rx),
    .opcode(opcode), .opdata(opdata), .execute(execute),
    .rx_byte(rx_byte), .rx_byte_valid(rx_byte_valid), .frame_err(frame_err)
  );

  typedef struct packed {
    logic [7:0]  op;
    logic [31:0] data;
  } cmd_t;

  typedef struct {
    int          n;
    logic [39:0] bytes;
    logic [7:0]  op;
    logic [31:0] data;
  } vec_t;

  int   checks = 0;
  int   errors = 0;
  cmd_t exec_q[$];
  cmd_t exp_q[$];
  int   rxv_cnt = 0;
  int   ferr_cnt = 0;
  int   hold_viol = 0;
  logic [7:0]  last_rx = '0;
  logic [39:0] prev = '0;

  always @(negedge clock) begin
    if (extReset_n) begin
      if (execute) exec_q.push_back({opcode, opdata});
      else if ({opcode, opdata} != prev) hold_viol++;
      if (rx_byte_valid) begin
        rxv_cnt++;
        last_rx = rx_byte;
      end
      if (frame_err) ferr_cnt++;
    end
    prev = {opcode, opdata};
  end

  task automatic check(input string name, input logic [39:0] act, input logic [39:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic clear_obs();
    exec_q.delete();
    exp_q.delete();
    rxv_cnt  = 0;
    ferr_cnt = 0;
  endtask

  task automatic verify(input string name, input int exp_rxv, input int exp_ferr);
    check({name, "_exec_count"}, 40'(exec_q.size()), 40'(exp_q.size()));
    for (int i = 0; i < exec_q.size() && i < exp_q.size(); i++) begin
      check({name, "_opcode"}, 40'(exec_q[i].op), 40'(exp_q[i].op));
      check({name, "_opdata"}, 40'(exec_q[i].data), 40'(exp_q[i].data));
    end
    check({name, "_rxv_count"}, 40'(rxv_cnt), 40'(exp_rxv));
    check({name, "_ferr_count"}, 40'(ferr_cnt), 40'(exp_ferr));
    clear_obs();
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop_bit);
    rx = 1'b0;
    idle(BL);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      idle(BL);
    end
    rx = stop_bit;
    idle(BL);
    rx = 1'b1;
  endtask

  vec_t vecs[6];

  initial begin
    vecs[0] = '{1, 40'h00_0000_0000, 8'h00, 32'h0000_0000};
    vecs[1] = '{5, 40'h04_0302_01C0, 8'hC0, 32'h0403_0201};
    vecs[2] = '{1, 40'h00_0000_0002, 8'h02, 32'h0000_0000};
    vecs[3] = '{1, 40'h00_0000_007F, 8'h7F, 32'h0000_0000};
    vecs[4] = '{5, 40'hFF_FFFF_FFFF, 8'hFF, 32'hFFFF_FFFF};
    vecs[5] = '{5, 40'h01_7F00_8082, 8'h82, 32'h017F_0080};

    rx = 1'b1;
    extReset_n = 1'b0;
    idle(3);
    check("reset_opcode", 40'(opcode), 40'h00);
    check("reset_opdata", 40'(opdata), 40'h0);
    check("reset_execute", 40'(execute), 40'h0);
    check("reset_rx_byte", 40'(rx_byte), 40'h00);
    check("reset_rx_valid", 40'(rx_byte_valid), 40'h0);
    check("reset_frame_err", 40'(frame_err), 40'h0);
    extReset_n = 1'b1;
    idle(10);
    clear_obs();

    // Table vectors, bytes sent back-to-back
    for (int v = 0; v < 6; v++) begin
      for (int k = 0; k < vecs[v].n; k++) send_byte(vecs[v].bytes[8*k +: 8], 1'b1);
      idle(6);
      exp_q.push_back('{vecs[v].op, vecs[v].data});
      check("vec_last_rx", 40'(last_rx), 40'(vecs[v].bytes[8*(vecs[v].n-1) +: 8]));
      verify($sformatf("vec%0d", v), vecs[v].n, 0);
    end

    // Short glitch must be rejected as a false start
    rx = 1'b0;
    idle(5);
    rx = 1'b1;
    idle(60);
    verify("glitch", 0, 0);

    // Bad stop bit, line held low, then a valid short command
    send_byte(8'h55, 1'b0);
    rx = 1'b0;
    idle(100);
    rx = 1'b1;
    idle(20);
    send_byte(8'h11, 1'b1);
    idle(6);
    exp_q.push_back('{8'h11, 32'h0});
    verify("frame_err", 1, 1);

    // Framing error in the middle of a long command drops it
    send_byte(8'h80, 1'b1);
    send_byte(8'h01, 1'b1);
    send_byte(8'h33, 1'b0);
    idle(20);
    send_byte(8'h13, 1'b1);
    idle(6);
    exp_q.push_back('{8'h13, 32'h0});
    verify("ferr_mid_long", 3, 1);

    // Long pause inside a long command
    send_byte(8'h80, 1'b1);
    send_byte(8'hAA, 1'b1);
    idle(1100);
    send_byte(8'h02, 1'b1);
    idle(6);
`ifdef SUMP_RX_TIMEOUT_EN
    exp_q.push_back('{8'h02, 32'h0});
    verify("timeout", 3, 0);
`else
    verify("no_timeout_wait", 3, 0);
    send_byte(8'h03, 1'b1);
    send_byte(8'h04, 1'b1);
    idle(6);
    exp_q.push_back('{8'h80, 32'h0403_02AA});
    verify("no_timeout_complete", 2, 0);
`endif

    // Async reset in the middle of the third byte of a long command
    send_byte(8'h81, 1'b1);
    send_byte(8'h01, 1'b1);
    rx = 1'b0;
    idle(BL);
    rx = 1'b1;
    idle(BL + 5);
    extReset_n = 1'b0;
    idle(2);
    check("mid_reset_opcode", 40'(opcode), 40'h00);
    check("mid_reset_opdata", 40'(opdata), 40'h0);
    check("mid_reset_rx_byte", 40'(rx_byte), 40'h00);
    check("mid_reset_strobes", 40'({execute, rx_byte_valid, frame_err}), 40'h0);
    idle(3);
    extReset_n = 1'b1;
    idle(20);
    clear_obs();
    send_byte(8'h00, 1'b1);
    idle(6);
    exp_q.push_back('{8'h00, 32'h0});
    verify("after_reset", 1, 0);

    // Random short/long commands with random inter-byte gaps
    begin
      int nbytes;
      nbytes = 0;
      for (int m = 0; m < 20; m++) begin
        logic [7:0]  b0;
        logic [31:0] d;
        b0 = 8'($urandom_range(0, 255));
        d  = $urandom;
        send_byte(b0, 1'b1);
        nbytes++;
        if (b0 >= 8'h80) begin
          for (int k = 0; k < 4; k++) begin
            if ($urandom_range(0, 2) != 0) idle($urandom_range(1, 40));
            send_byte(d[8*k +: 8], 1'b1);
            nbytes++;
          end
          exp_q.push_back('{b0, d});
        end else begin
          exp_q.push_back('{b0, 32'h0});
        end
        if ($urandom_range(0, 2) != 0) idle($urandom_range(1, 40));
      end
      idle(6);
      verify("random", nbytes, 0);
    end

    check("hold_violations", 40'(hold_viol), 40'h0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/sump_cmd_receiver.md
# sump_cmd_receiver

UART receive path and SUMP command assembler for the logic-analyzer core. Deserialises 8N1 bytes from the host `rx` pin, groups them into SUMP commands (1-byte short, or 1 opcode + 4 data bytes long) and presents each complete command to the command decoder with a single-cycle `execute` strobe. Sits directly upstream of the decoder/controller that drives the serial transmitter's `send`/`query_*` inputs, and uses the same FREQ/RATE bit-timing scheme as the transmitter.

## Interface
- FREQ, 100000000: clock frequency, Hz
- RATE, 115200: baud rate
- BITLENGTH, FREQ/RATE: clocks per bit; legal range 4..65535
- TIMEOUT_BITS, 1024: inter-byte timeout for long commands, in bit periods; legal range 1..65535
- clock  in  1  sole clock
- extReset_n  in  1  asynchronous active-low reset
- rx  in  1  asynchronous serial input, idle high
- opcode  out  8  opcode of last completed command
- opdata  out  32  data of last completed command, little-endian (first data byte = [7:0])
- execute  out  1  one-cycle strobe: opcode/opdata valid, new command
- rx_byte  out  8  last correctly framed byte
- rx_byte_valid  out  1  one-cycle strobe per correctly framed byte
- frame_err  out  1  one-cycle strobe on bad stop bit

## Operation
- `rx` double-flopped; both flops reset to 1. All logic uses the synchronised signal `rxs`.
- Bit FSM: RX_IDLE, RX_START, RX_DATA, RX_STOP, RX_BREAK. 16-bit bit counter, 3-bit bit index.
- RX_IDLE: `rxs`=0 -> RX_START, counter cleared.
- RX_START: at count BITLENGTH/2-1 resample; `rxs`=1 -> false start, back to RX_IDLE; `rxs`=0 -> RX_DATA, counter cleared.
- RX_DATA: sample every BITLENGTH clocks (mid-bit), LSB first, shift into byte; after 8th sample -> RX_STOP.
- RX_STOP: sample after BITLENGTH clocks. 1 -> `rx_byte_valid` strobe, RX_IDLE. 0 -> `frame_err` strobe, byte dropped, command FSM forced to CMD_OP, -> RX_BREAK.
- RX_BREAK: wait for `rxs`=1, then RX_IDLE (held-low line produces exactly one `frame_err`).
- Command FSM: CMD_OP, CMD_DATA (2-bit data index).
  - CMD_OP, byte with bit7=0: opcode <= byte, opdata <= 0, `execute`.
  - CMD_OP, byte with bit7=1: latch opcode internally, data index 0, -> CMD_DATA.
  - CMD_DATA: byte into lane `index`; on 4th byte update opcode/opdata together, `execute`, -> CMD_OP.
- `opcode`/`opdata` change only in the cycle `execute` is asserted; they hold between commands.

## Timing
- Reset: opcode 0x00, opdata 0x00000000, execute 0, rx_byte 0x00, rx_byte_valid 0, frame_err 0; both FSMs at idle states.
- `rx_byte_valid` asserts the cycle after the stop-bit sample clock; `execute` asserts the following cycle (1 clock behind `rx_byte_valid` of the completing byte).
- Synchroniser adds 2 clocks from pin to `rxs`.
- Strobes are exactly one cycle; no downstream backpressure (decoder must accept every `execute`).
- Back-to-back bytes with zero idle time are accepted: RX_IDLE detects the next start bit in the cycle after the stop sample.
- Async reset mid-byte or mid-command discards all partial state; the next start bit begins a fresh opcode.

## Configuration
- `SUMP_RX_TIMEOUT_EN` defined: in CMD_DATA a 16-bit bit-period counter (ticks every BITLENGTH clocks, cleared on each accepted byte) reaching TIMEOUT_BITS discards the partial long command and returns to CMD_OP; no strobe.
- Undefined: no timeout logic; CMD_DATA waits indefinitely for its remaining bytes.

## Structure
- Shared package: FSM state encodings (RX_*, CMD_*), long-command flag bit position (7), SUMP short-opcode constants used by the decoder.
- One sub-module: `uart_rx_byte` (synchroniser + bit FSM, outputs byte/valid/frame_err); command FSM and timeout in the top.

## Test plan
(Bench: FREQ=16, RATE=1 -> BITLENGTH=16; TIMEOUT_BITS=64.)
- Send 0x00 -> one `execute`, opcode 0x00, opdata 0x00000000, `rx_byte_valid` exactly once.
- Send 0xC0,0x01,0x02,0x03,0x04 back-to-back -> single `execute` after 5th byte, opcode 0xC0, opdata 0x04030201; no strobe after bytes 1-4.
- Pulse `rx` low 5 clocks -> no `rx_byte_valid`, no `frame_err`, no `execute`.
- Byte 0x55 with stop bit 0, line held low 100 clocks, then valid 0x11 -> exactly one `frame_err`, then `execute` with opcode 0x11.
- Send 0x80,0xAA, idle 1100 clocks, send 0x02 -> with `SUMP_RX_TIMEOUT_EN`: `execute` opcode 0x02, opdata 0; without: no `execute`, 0x02 stored as data byte 1.
- Send 0x81,0x01, pulse `extReset_n` low mid-3rd byte -> all outputs return to reset values; next 0x00 -> `execute` opcode 0x00.
